clock_set_ctrl: RTL and testbench

//  Time-setting controller that sequences the 24-h BCD clock datapath (hr/mn/sd, 8-bit packed BCD).
//  It pauses the clock, captures the current time into edit registers and steps the user through
//  the HR, MN and SD fields using single-cycle button pulses (already debounced upstream).
//  On commit it drives a one-cycle load of the edited time into the clock.
//  It also provides field-select and blink outputs for the 7-seg display driver.

---
 rtl/clock_set_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// clock_set_ctrl
//
// Time-setting controller for a 24-h BCD clock (hh/mm/ss, 8-bit packed BCD).
// When the user presses mode, the clock is paused and the current time is
// copied into edit registers. The user then steps through the HR, MN and SD
// fields with single-cycle button pulses. A commit from SD issues a one-cycle
// load of the edited time back into the clock. Cancel, or an idle timeout,
// returns to RUN without loading. The controller also drives the field-select
// and blink outputs for the 7-segment display.
//
// Ports
//   clk, rst_n              system clock, asynchronous active-low reset
//   btn_mode                pulse: enter set / advance field / commit
//   btn_inc, btn_dec        pulse: increment / decrement the selected field
//   btn_cancel              pulse: abort the edit, no load
//   hr_in, mn_in, sd_in     current clock time, BCD
//   run_en                  1 = clock may count, 0 = clock held
//   load                    one-cycle strobe: the clock takes hr_ld/mn_ld/sd_ld
//   hr_ld, mn_ld, sd_ld     edited time, BCD
//   edit_sel                00 none, 01 HR, 10 MN, 11 SD
//   blink                   display enable for the selected field (1 = show)
// -----------------------------------------------------------------------------
module clock_set_ctrl #(
    parameter logic [31:0] BLINK_MAX   = 32'd25_000_000,
    parameter logic [31:0] TIMEOUT_MAX = 32'd500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_cancel,
    input  logic [7:0] hr_in,
    input  logic [7:0] mn_in,
    input  logic [7:0] sd_in,
    output logic       run_en,
    output logic       load,
    output logic [7:0] hr_ld,
    output logic [7:0] mn_ld,
    output logic [7:0] sd_ld,
    output logic [1:0] edit_sel,
    output logic       blink
);

    // The state codes match the edit_sel encoding, so edit_sel is simply the
    // state register.
    typedef enum logic [1:0] {
        RUN    = 2'b00,
        SET_HR = 2'b01,
        SET_MN = 2'b10,
        SET_SD = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hr_q, hr_d;
    logic [7:0]  mn_q, mn_d;
    logic [7:0]  sd_q, sd_d;
    logic        load_q, load_d;
    logic        blink_q, blink_d;
    logic [31:0] blink_cnt_q, blink_cnt_d;
    logic [31:0] idle_cnt_q, idle_cnt_d;

    // BCD increment with wrap from max_v back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v == max_v)
            return 8'h00;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // BCD decrement with wrap from 00 up to max_v.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
        if (v == 8'h00)
            return max_v;
        if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this clock edge, regardless of the order
    // of the statements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            hr_q        <= 8'h00;
            mn_q        <= 8'h00;
            sd_q        <= 8'h00;
            load_q      <= 1'b0;
            blink_q     <= 1'b0;
            blink_cnt_q <= '0;
            idle_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            hr_q        <= hr_d;
            mn_q        <= mn_d;
            sd_q        <= sd_d;
            load_q      <= load_d;
            blink_q     <= blink_d;
            blink_cnt_q <= blink_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a default first. Any path that
        // left one unassigned would otherwise infer a latch.
        state_d     = state_q;
        hr_d        = hr_q;
        mn_d        = mn_q;
        sd_d        = sd_q;
        load_d      = 1'b0;
        blink_d     = blink_q;
        blink_cnt_d = blink_cnt_q;
        idle_cnt_d  = idle_cnt_q;

        if (state_q == RUN) begin
            // In RUN, blink is off and both counters stay at 0.
            // inc, dec and cancel have no effect here.
            blink_d     = 1'b0;
            blink_cnt_d = '0;
            idle_cnt_d  = '0;
            if (btn_mode) begin
                hr_d    = hr_in;
                mn_d    = mn_in;
                sd_d    = sd_in;
                state_d = SET_HR;
                blink_d = 1'b1;
            end
        end else begin
            // Free-running blink and idle counters. The button handling
            // below overrides them.
            if (blink_cnt_q == BLINK_MAX) begin
                blink_d     = ~blink_q;
                blink_cnt_d = '0;
            end else begin
                blink_cnt_d = blink_cnt_q + 32'd1;
            end
            idle_cnt_d = idle_cnt_q + 32'd1;

            // Button priority: cancel > mode > inc/dec > idle timeout.
            if (btn_cancel) begin
                state_d     = RUN;
                blink_d     = 1'b0;
                blink_cnt_d = '0;
                idle_cnt_d  = '0;
            end else if (btn_mode) begin
                blink_d     = 1'b1;
                blink_cnt_d = '0;
                idle_cnt_d  = '0;
                case (state_q)
                    SET_HR:  state_d = SET_MN;
                    SET_MN:  state_d = SET_SD;
                    default: begin
                        state_d = RUN;
                        load_d  = 1'b1;
                        blink_d = 1'b0;
                    end
                endcase
            end else if (btn_inc || btn_dec) begin
                blink_d     = 1'b1;
                blink_cnt_d = '0;
                idle_cnt_d  = '0;
                // inc and dec together cancel out. The press still counts
                // as activity for the blink and idle counters.
                if (btn_inc != btn_dec) begin
                    case (state_q)
                        SET_HR:  hr_d = btn_inc ? bcd_inc(hr_q, 8'h23) : bcd_dec(hr_q, 8'h23);
                        SET_MN:  mn_d = btn_inc ? bcd_inc(mn_q, 8'h59) : bcd_dec(mn_q, 8'h59);
                        SET_SD:  sd_d = btn_inc ? bcd_inc(sd_q, 8'h59) : bcd_dec(sd_q, 8'h59);
                        default: ;
                    endcase
                end
            end else if (idle_cnt_q == TIMEOUT_MAX) begin
                // Auto-abort. This behaves the same as cancel.
                state_d     = RUN;
                blink_d     = 1'b0;
                blink_cnt_d = '0;
                idle_cnt_d  = '0;
            end
        end
    end

    // Every output comes straight from a register.
    assign run_en   = (state_q == RUN);
    assign edit_sel = state_q;
    assign load     = load_q;
    assign blink    = blink_q;
    assign hr_ld    = hr_q;
    assign mn_ld    = mn_q;
    assign sd_ld    = sd_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clock_set_ctrl
//
// Self-checking bench for clock_set_ctrl, using BLINK_MAX=4 and TIMEOUT_MAX=20.
// The reference model keeps the edited time as plain integers with modulo
// arithmetic. It tracks the cycles since the last activity and derives blink
// from that count by division.
// -----------------------------------------------------------------------------
module tb_clock_set_ctrl;

    localparam int BLINK_MAX   = 4;
    localparam int TIMEOUT_MAX = 20;

    logic       clk;
    logic       rst_n;
    logic       btn_mode, btn_inc, btn_dec, btn_cancel;
    logic [7:0] hr_in, mn_in, sd_in;
    logic       run_en, load, blink;
    logic [7:0] hr_ld, mn_ld, sd_ld;
    logic [1:0] edit_sel;

    int total = 0;
    int bad   = 0;

    // Reference model state. m_field: 0 run, 1 hours, 2 minutes, 3 seconds.
    int m_field;
    int m_hr, m_mn, m_sd;
    int m_k;          // cycles since the last activity while editing
    bit m_load;

    clock_set_ctrl #(
        .BLINK_MAX   (32'(BLINK_MAX)),
        .TIMEOUT_MAX (32'(TIMEOUT_MAX))
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_mode   (btn_mode),
        .btn_inc    (btn_inc),
        .btn_dec    (btn_dec),
        .btn_cancel (btn_cancel),
        .hr_in      (hr_in),
        .mn_in      (mn_in),
        .sd_in      (sd_in),
        .run_en     (run_en),
        .load       (load),
        .hr_ld      (hr_ld),
        .mn_ld      (mn_ld),
        .sd_ld      (sd_ld),
        .edit_sel   (edit_sel),
        .blink      (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------------------------------------------------------- model
    function automatic int bcd2int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int2bcd(input int n);
        logic [3:0] tens, ones;
        tens = 4'(n / 10);
        ones = 4'(n % 10);
        return {tens, ones};
    endfunction

    function automatic logic [7:0] rand_bcd(input int max_n);
        return int2bcd(int'($urandom_range(0, max_n)));
    endfunction

    task automatic model_reset();
        m_field = 0;
        m_hr = 0; m_mn = 0; m_sd = 0;
        m_k = 0;
        m_load = 1'b0;
    endtask

    task automatic model_step(input bit m, input bit inc, input bit dec, input bit can);
        int d;
        m_load = 1'b0;
        if (m_field == 0) begin
            if (m) begin
                m_hr = bcd2int(hr_in);
                m_mn = bcd2int(mn_in);
                m_sd = bcd2int(sd_in);
                m_field = 1;
                m_k = 0;
            end
        end else if (can) begin
            m_field = 0;
        end else if (m) begin
            m_k = 0;
            if (m_field == 3) begin
                m_field = 0;
                m_load = 1'b1;
            end else begin
                m_field = m_field + 1;
            end
        end else if (inc || dec) begin
            m_k = 0;
            d = (inc && !dec) ? 1 : ((dec && !inc) ? -1 : 0);
            case (m_field)
                1: m_hr = (m_hr + d + 24) % 24;
                2: m_mn = (m_mn + d + 60) % 60;
                default: m_sd = (m_sd + d + 60) % 60;
            endcase
        end else if (m_k == TIMEOUT_MAX) begin
            m_field = 0;
        end else begin
            m_k = m_k + 1;
        end
    endtask

    function automatic logic [28:0] exp_vec();
        logic b;
        b = (m_field != 0) && (((m_k / (BLINK_MAX + 1)) % 2) == 0);
        return {(m_field == 0), m_load, int2bcd(m_hr), int2bcd(m_mn), int2bcd(m_sd),
                2'(m_field), b};
    endfunction

    function automatic logic [28:0] act_vec();
        return {run_en, load, hr_ld, mn_ld, sd_ld, edit_sel, blink};
    endfunction

    // Apply one cycle of buttons, advance the model, and leave outputs ready
    // for sampling #1 after the edge.
    task automatic tick(input bit m, input bit inc, input bit dec, input bit can);
        btn_mode = m; btn_inc = inc; btn_dec = dec; btn_cancel = can;
        @(posedge clk);
        #1;
        model_step(m, inc, dec, can);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        total++;
        if (act_vec() !== {1'b1, 1'b0, 24'h000000, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL reset_held got=%h exp=%h", act_vec(), {1'b1, 1'b0, 24'h000000, 2'b00, 1'b0});
        end
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) tick(0, 0, 0, 0);
        total++;
        if ({run_en, load, edit_sel, blink} !== 5'b1_0_00_0) begin
            bad++;
            $display("FAIL reset_idle got=%b exp=%b", {run_en, load, edit_sel, blink}, 5'b1_0_00_0);
        end
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL reset_model got=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_walkthrough();
        int loads = 0;
        hr_in = 8'h23; mn_in = 8'h59; sd_in = 8'h07;
        tick(1, 0, 0, 0);  // enter SET_HR
        total++;
        if ({run_en, edit_sel, hr_ld, mn_ld, sd_ld} !== {1'b0, 2'b01, 24'h235907}) begin
            bad++;
            $display("FAIL walk_capture got=%h exp=%h", {run_en, edit_sel, hr_ld, mn_ld, sd_ld},
                     {1'b0, 2'b01, 24'h235907});
        end
        tick(0, 1, 0, 0);  // HR 23 -> 00
        total++;
        if (hr_ld !== 8'h00) begin
            bad++;
            $display("FAIL walk_hr_wrap got=%h exp=00", hr_ld);
        end
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);  // MN 59 -> 00, HR unaffected
        total++;
        if ({hr_ld, mn_ld, edit_sel} !== {8'h00, 8'h00, 2'b10}) begin
            bad++;
            $display("FAIL walk_mn_wrap got=%h exp=%h", {hr_ld, mn_ld, edit_sel}, {8'h00, 8'h00, 2'b10});
        end
        tick(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 1, 0);
            if (load) loads++;
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL walk_sd_dec%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
        tick(1, 0, 0, 0);  // commit
        if (load) loads++;
        total++;
        if ({load, run_en, hr_ld, mn_ld, sd_ld} !== {1'b1, 1'b1, 24'h000059}) begin
            bad++;
            $display("FAIL walk_commit got=%h exp=%h", {load, run_en, hr_ld, mn_ld, sd_ld},
                     {1'b1, 1'b1, 24'h000059});
        end
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            if (load) loads++;
        end
        total++;
        if (loads != 1 || hr_ld !== 8'h00 || sd_ld !== 8'h59) begin
            bad++;
            $display("FAIL walk_single_load loads=%0d hr=%h sd=%h exp loads=1 hr=00 sd=59", loads, hr_ld, sd_ld);
        end
    endtask

    task automatic test_borrow_carry();
        hr_in = 8'h00; mn_in = 8'h39; sd_in = 8'h12;
        tick(1, 0, 0, 0);
        tick(0, 0, 1, 0);  // HR 00 -> 23
        total++;
        if (hr_ld !== 8'h23) begin
            bad++;
            $display("FAIL hr_dec_wrap got=%h exp=23", hr_ld);
        end
        tick(1, 0, 0, 0);
        tick(0, 1, 0, 0);  // MN 39 -> 40
        total++;
        if (mn_ld !== 8'h40) begin
            bad++;
            $display("FAIL mn_inc_carry got=%h exp=40", mn_ld);
        end
        tick(0, 0, 1, 0);  // MN 40 -> 39 (borrow)
        total++;
        if (mn_ld !== 8'h39) begin
            bad++;
            $display("FAIL mn_dec_borrow got=%h exp=39", mn_ld);
        end
        tick(0, 0, 0, 1);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL borrow_cancel got=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_inc_dec_cancel();
        int loads = 0;
        hr_in = 8'h12; mn_in = 8'h34; sd_in = 8'h56;
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);  // SET_MN
        tick(0, 1, 1, 0);  // inc+dec: no change
        if (load) loads++;
        total++;
        if ({mn_ld, edit_sel} !== {8'h34, 2'b10}) begin
            bad++;
            $display("FAIL incdec_together got=%h exp=%h", {mn_ld, edit_sel}, {8'h34, 2'b10});
        end
        tick(0, 1, 0, 1);  // cancel beats inc
        if (load) loads++;
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0);
            if (load) loads++;
        end
        total++;
        if ({run_en, edit_sel, hr_ld, mn_ld, sd_ld} !== {1'b1, 2'b00, 24'h123456} || loads != 0) begin
            bad++;
            $display("FAIL cancel_no_load got=%h loads=%0d exp=%h loads=0",
                     {run_en, edit_sel, hr_ld, mn_ld, sd_ld}, loads, {1'b1, 2'b00, 24'h123456});
        end
        tick(0, 1, 1, 1);  // inc/dec/cancel in RUN are ignored
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL run_ignore got=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_timeout_blink();
        int loads = 0;
        hr_in = 8'h08; mn_in = 8'h09; sd_in = 8'h10;
        tick(1, 0, 0, 0);  // j = 0
        for (int j = 0; j <= TIMEOUT_MAX; j++) begin
            if (j > 0) tick(0, 0, 0, 0);
            if (load) loads++;
            total++;
            if ({run_en, edit_sel, blink} !== {1'b0, 2'b01, ((j / 5) % 2) == 0}) begin
                bad++;
                $display("FAIL blink_j%0d got=%b exp=%b", j, {run_en, edit_sel, blink},
                         {1'b0, 2'b01, ((j / 5) % 2) == 0});
            end
        end
        tick(0, 0, 0, 0);
        if (load) loads++;
        total++;
        if ({run_en, edit_sel, blink} !== 4'b1_00_0 || loads != 0) begin
            bad++;
            $display("FAIL timeout_abort got=%b loads=%0d exp=1000 loads=0", {run_en, edit_sel, blink}, loads);
        end
        // On the cycle the timeout would fire, a button press takes priority.
        tick(1, 0, 0, 0);
        for (int j = 0; j < TIMEOUT_MAX; j++) tick(0, 0, 0, 0);
        tick(0, 1, 0, 0);
        total++;
        if ({run_en, edit_sel, hr_ld, blink} !== {1'b0, 2'b01, 8'h09, 1'b1}) begin
            bad++;
            $display("FAIL timeout_button_wins got=%h exp=%h", {run_en, edit_sel, hr_ld, blink},
                     {1'b0, 2'b01, 8'h09, 1'b1});
        end
        for (int j = 0; j <= TIMEOUT_MAX; j++) tick(0, 0, 0, 0);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++;
            $display("FAIL timeout_restart got=%h exp=%h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 1500; i++) begin
            hr_in = rand_bcd(23); mn_in = rand_bcd(59); sd_in = rand_bcd(59);
            if ((i % 250) >= 220) begin
                tick(0, 0, 0, 0);  // idle burst so timeouts occur
            end else begin
                r = int'($urandom_range(0, 15));
                case (r)
                    0, 1, 2:    tick(1, 0, 0, 0);
                    3, 4, 5, 6: tick(0, 1, 0, 0);
                    7, 8, 9:    tick(0, 0, 1, 0);
                    10:         tick(0, 1, 1, 0);
                    11:         tick(0, 0, 0, 1);
                    12:         tick($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                     $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
                    default:    tick(0, 0, 0, 0);
                endcase
            end
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++;
                $display("FAIL random_c%0d got=%h exp=%h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        int loads = 0;
        hr_in = 8'h17; mn_in = 8'h45; sd_in = 8'h30;
        if (m_field != 0) tick(0, 0, 0, 1);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);  // SET_SD
        total++;
        if (edit_sel !== 2'b11) begin
            bad++;
            $display("FAIL areset_setup got=%b exp=11", edit_sel);
        end
        #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (act_vec() !== {1'b1, 1'b0, 24'h000000, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL areset_immediate got=%h exp=%h", act_vec(), {1'b1, 1'b0, 24'h000000, 2'b00, 1'b0});
        end
        model_reset();
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 0);
            if (load) loads++;
        end
        total++;
        if (act_vec() !== exp_vec() || loads != 0) begin
            bad++;
            $display("FAIL areset_after got=%h loads=%0d exp=%h loads=0", act_vec(), loads, exp_vec());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_cancel = 1'b0;
        hr_in = 8'h00; mn_in = 8'h00; sd_in = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_walkthrough();
        test_borrow_carry();
        test_inc_dec_cancel();
        test_timeout_blink();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
